// File: rtl/trace_pkg.sv
// Shared types and encodings for the commit trace buffer: record kinds,
// CSR command codes, register-type codes and a default-geometry record layout.
package trace_pkg;

  localparam int CYCLE_BITS      = 64;
  localparam int TRACE_XLEN      = 64;
  localparam int TRACE_ADDR_BITS = 40;

  typedef enum logic [1:0] {
    KIND_GPR    = 2'd0,
    KIND_FPR    = 2'd1,
    KIND_RETIRE = 2'd2,
    KIND_CSR    = 2'd3
  } trace_kind_e;

  localparam logic [2:0] CSR_CMD_WRITE = 3'h5;
  localparam logic [2:0] CSR_CMD_SET   = 3'h6;
  localparam logic [2:0] CSR_CMD_CLEAR = 3'h7;

  localparam logic [2:0] RTYPE_GPR = 3'd0;
  localparam logic [2:0] RTYPE_FPR = 3'd1;

  // Record layout for the default XLEN/ADDR_BITS geometry; the top builds
  // the same layout from its own parameters.
  typedef struct packed {
    trace_kind_e                kind;
    logic [CYCLE_BITS-1:0]      cycle;
    logic [TRACE_ADDR_BITS-1:0] pc;
    logic [31:0]                inst;
    logic [11:0]                addr;
    logic [TRACE_XLEN-1:0]      data;
  } trace_rec_t;

  function automatic trace_kind_e rtype_to_kind(input logic [2:0] rtype);
    trace_kind_e kind;
    kind = KIND_RETIRE;
    if (rtype == RTYPE_GPR) kind = KIND_GPR;
    else if (rtype == RTYPE_FPR) kind = KIND_FPR;
    return kind;
  endfunction

  function automatic logic is_csr_cmd(input logic [2:0] cmd);
    return (cmd == CSR_CMD_WRITE) || (cmd == CSR_CMD_SET) || (cmd == CSR_CMD_CLEAR);
  endfunction

endpackage

// File: rtl/commit_trace_buffer_if.sv
// Valid/ready trace record stream from the buffer (master) to a trace sink (slave).
interface commit_trace_buffer_if #(
  parameter int XLEN      = 64,
  parameter int ADDR_BITS = 40
);
  import trace_pkg::*;

  logic                  out_valid;
  logic                  out_ready;
  trace_kind_e           out_kind;
  logic [CYCLE_BITS-1:0] out_cycle;
  logic [ADDR_BITS-1:0]  out_pc;
  logic [31:0]           out_inst;
  logic [11:0]           out_addr;
  logic [XLEN-1:0]       out_data;

  modport master (
    output out_valid, out_kind, out_cycle, out_pc, out_inst, out_addr, out_data,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_kind, out_cycle, out_pc, out_inst, out_addr, out_data,
    output out_ready
  );

endinterface

// File: rtl/trace_mpush_fifo.sv
// FIFO accepting up to MAX_PUSH pre-compacted records per cycle and popping
// one; the caller guarantees push_count never exceeds the free space.
module trace_mpush_fifo
  import trace_pkg::*;
#(
  parameter type rec_t    = logic [7:0],
  parameter int  DEPTH    = 16,
  parameter int  MAX_PUSH = 4
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  rec_t                            push_data [MAX_PUSH],
  input  logic [$clog2(MAX_PUSH+1)-1:0]   push_count,
  input  logic                            pop,
  output rec_t                            head,
  output logic [$clog2(DEPTH):0]          occupancy
);

  localparam int CNT_W = $clog2(MAX_PUSH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  rec_t             mem_q [DEPTH];
  rec_t             mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             pop_ok;

  // Slot k of the push vector lands k entries past the write pointer; the
  // pointer arithmetic wraps naturally because DEPTH is a power of two.
  always_comb begin
    mem_d = mem_q;
    for (int k = 0; k < MAX_PUSH; k++) begin
      if (CNT_W'(k) < push_count) begin
        mem_d[wr_ptr_q + PTR_W'(k)] = push_data[k];
      end
    end
    pop_ok   = pop && (occ_q != '0);
    wr_ptr_d = wr_ptr_q + PTR_W'(push_count);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
    occ_d    = occ_q + OCC_W'(push_count) - OCC_W'(pop_ok);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  assign head      = mem_q[rd_ptr_q];
  assign occupancy = occ_q;

endmodule

// File: rtl/commit_trace_buffer.sv
// Captures per-cycle retire and CSR events with a cycle timestamp, packs them
// in order into a multi-push FIFO and streams one record per cycle to a sink.
module commit_trace_buffer
  import trace_pkg::*;
#(
  parameter int RETIRE_WIDTH = 3,
  parameter int XLEN         = 64,
  parameter int ADDR_BITS    = 40,
  parameter int DEPTH        = 16,
  parameter int DROP_MODE    = 0
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         enable,
  input  logic [RETIRE_WIDTH-1:0]      commit_valid,
  input  logic [RETIRE_WIDTH*ADDR_BITS-1:0] commit_pc,
  input  logic [RETIRE_WIDTH*32-1:0]   commit_inst,
  input  logic [RETIRE_WIDTH*3-1:0]    commit_rtype,
  input  logic [RETIRE_WIDTH*5-1:0]    commit_ldst,
  input  logic [RETIRE_WIDTH*XLEN-1:0] commit_wdata,
  input  logic [2:0]                   csr_cmd,
  input  logic [11:0]                  csr_addr,
  input  logic [XLEN-1:0]              csr_wdata,
  input  logic [XLEN-1:0]              csr_rdata,
  commit_trace_buffer_if.master        trace_out,
  output logic                         stall_req,
  output logic                         overflow,
  output logic [31:0]                  drop_count,
  output logic [$clog2(DEPTH):0]       occupancy
);

  localparam int MAX_EV = RETIRE_WIDTH + 1;
  localparam int CNT_W  = $clog2(MAX_EV + 1);
  localparam int OCC_W  = $clog2(DEPTH) + 1;

  typedef struct packed {
    trace_kind_e           kind;
    logic [CYCLE_BITS-1:0] cycle;
    logic [ADDR_BITS-1:0]  pc;
    logic [31:0]           inst;
    logic [11:0]           addr;
    logic [XLEN-1:0]       data;
  } rec_t;

  logic [CYCLE_BITS-1:0] cycle_q, cycle_d;
  logic                  stall_q, stall_d;
  logic                  overflow_q, overflow_d;
  logic [31:0]           drop_q, drop_d;
  logic [32:0]           drop_sum;

  logic [XLEN-1:0]  csr_value;
  logic [MAX_EV-1:0] ev_valid;
  rec_t             ev_rec   [MAX_EV];
  logic [CNT_W-1:0] ev_pos   [MAX_EV];
  logic [CNT_W-1:0] ev_count;
  rec_t             push_vec [MAX_EV];
  logic [CNT_W-1:0] push_count;

  rec_t             head;
  logic             head_valid;
  logic             pop;
  logic             accept;
  logic [OCC_W-1:0] fifo_occ;
  logic [OCC_W-1:0] free_now, occ_next, free_next;

  always_comb begin
    case (csr_cmd)
      CSR_CMD_WRITE: csr_value = csr_wdata;
      CSR_CMD_SET:   csr_value = csr_rdata | csr_wdata;
      CSR_CMD_CLEAR: csr_value = csr_rdata & ~csr_wdata;
      default:       csr_value = '0;
    endcase
  end

  // Candidate events: retire lanes in lane order, then the CSR slot last.
  always_comb begin
    trace_kind_e lane_kind;
    ev_valid = '0;
    for (int l = 0; l < RETIRE_WIDTH; l++) begin
      lane_kind        = rtype_to_kind(commit_rtype[l*3 +: 3]);
      ev_valid[l]      = enable && commit_valid[l];
      ev_rec[l].kind   = lane_kind;
      ev_rec[l].cycle  = cycle_q;
      ev_rec[l].pc     = commit_pc[l*ADDR_BITS +: ADDR_BITS];
      ev_rec[l].inst   = commit_inst[l*32 +: 32];
      ev_rec[l].addr   = {7'd0, commit_ldst[l*5 +: 5]};
      ev_rec[l].data   = (lane_kind == KIND_RETIRE) ? '0 : commit_wdata[l*XLEN +: XLEN];
    end
    ev_valid[RETIRE_WIDTH]       = enable && is_csr_cmd(csr_cmd);
    ev_rec[RETIRE_WIDTH].kind    = KIND_CSR;
    ev_rec[RETIRE_WIDTH].cycle   = cycle_q;
    ev_rec[RETIRE_WIDTH].pc      = '0;
    ev_rec[RETIRE_WIDTH].inst    = '0;
    ev_rec[RETIRE_WIDTH].addr    = csr_addr;
    ev_rec[RETIRE_WIDTH].data    = csr_value;
  end

  // Each valid event's slot is the number of valid events ahead of it, so
  // invalid lanes leave no holes in the push vector.
  always_comb begin
    ev_count = '0;
    for (int e = 0; e < MAX_EV; e++) begin
      ev_pos[e] = ev_count;
      if (ev_valid[e]) ev_count = ev_count + CNT_W'(1);
    end
  end

  always_comb begin
    for (int k = 0; k < MAX_EV; k++) begin
      push_vec[k] = '0;
      for (int e = k; e < MAX_EV; e++) begin
        if (ev_valid[e] && (ev_pos[e] == CNT_W'(k))) push_vec[k] = ev_rec[e];
      end
    end
  end

  // Space is judged against the occupancy at the start of the cycle, so a
  // same-cycle pop never makes room for this cycle's events.
  always_comb begin
    cycle_d    = cycle_q + CYCLE_BITS'(1);
    head_valid = (fifo_occ != '0);
    pop        = head_valid && trace_out.out_ready;
    free_now   = OCC_W'(DEPTH) - fifo_occ;
    accept     = OCC_W'(ev_count) <= free_now;
    push_count = accept ? ev_count : '0;
    occ_next   = fifo_occ + OCC_W'(push_count) - OCC_W'(pop);
    free_next  = OCC_W'(DEPTH) - occ_next;
    stall_d    = (DROP_MODE == 0) && (free_next < OCC_W'(MAX_EV));
    overflow_d = overflow_q;
    drop_d     = drop_q;
    drop_sum   = {1'b0, drop_q} + 33'(ev_count);
    if (!accept) begin
      overflow_d = 1'b1;
      drop_d     = drop_sum[32] ? '1 : drop_sum[31:0];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cycle_q    <= '0;
      stall_q    <= 1'b0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      cycle_q    <= cycle_d;
      stall_q    <= stall_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  trace_mpush_fifo #(
    .rec_t    (rec_t),
    .DEPTH    (DEPTH),
    .MAX_PUSH (MAX_EV)
  ) u_fifo (
    .clock      (clock),
    .reset_n    (reset_n),
    .push_data  (push_vec),
    .push_count (push_count),
    .pop        (pop),
    .head       (head),
    .occupancy  (fifo_occ)
  );

  assign trace_out.out_valid = head_valid;
  assign trace_out.out_kind  = head.kind;
  assign trace_out.out_cycle = head.cycle;
  assign trace_out.out_pc    = head.pc;
  assign trace_out.out_inst  = head.inst;
  assign trace_out.out_addr  = head.addr;
  assign trace_out.out_data  = head.data;

  assign stall_req  = stall_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_q;
  assign occupancy  = fifo_occ;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed bench driving three buffer configurations from shared commit inputs:
// default (DEPTH 16, stall), DEPTH 4 drop mode, DEPTH 8 stall mode.
module tb_commit_trace_buffer;
  import trace_pkg::*;

  localparam int RW = 3;
  localparam int XL = 64;
  localparam int AB = 40;

  logic            clock = 1'b0;
  logic            reset_n = 1'b1;
  logic            enable;
  logic [RW-1:0]   commit_valid;
  logic [RW*AB-1:0] commit_pc;
  logic [RW*32-1:0] commit_inst;
  logic [RW*3-1:0] commit_rtype;
  logic [RW*5-1:0] commit_ldst;
  logic [RW*XL-1:0] commit_wdata;
  logic [2:0]      csr_cmd;
  logic [11:0]     csr_addr;
  logic [XL-1:0]   csr_wdata, csr_rdata;

  logic        stall0, stall1, stall2;
  logic        ovf0, ovf1, ovf2;
  logic [31:0] drop0, drop1, drop2;
  logic [4:0]  occ0;
  logic [2:0]  occ1;
  logic [3:0]  occ2;

  int total = 0;
  int bad = 0;
  logic [63:0] tb_cycle;
  logic [63:0] cyc;
  trace_rec_t  bp_exp [6];

  commit_trace_buffer_if #(.XLEN(XL), .ADDR_BITS(AB)) if0 ();
  commit_trace_buffer_if #(.XLEN(XL), .ADDR_BITS(AB)) if1 ();
  commit_trace_buffer_if #(.XLEN(XL), .ADDR_BITS(AB)) if2 ();

  commit_trace_buffer #(.RETIRE_WIDTH(RW), .XLEN(XL), .ADDR_BITS(AB), .DEPTH(16), .DROP_MODE(0)) dut0 (
    .clock(clock), .reset_n(reset_n), .enable(enable), .commit_valid(commit_valid),
    .commit_pc(commit_pc), .commit_inst(commit_inst), .commit_rtype(commit_rtype),
    .commit_ldst(commit_ldst), .commit_wdata(commit_wdata), .csr_cmd(csr_cmd),
    .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .trace_out(if0),
    .stall_req(stall0), .overflow(ovf0), .drop_count(drop0), .occupancy(occ0)
  );

  commit_trace_buffer #(.RETIRE_WIDTH(RW), .XLEN(XL), .ADDR_BITS(AB), .DEPTH(4), .DROP_MODE(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .enable(enable), .commit_valid(commit_valid),
    .commit_pc(commit_pc), .commit_inst(commit_inst), .commit_rtype(commit_rtype),
    .commit_ldst(commit_ldst), .commit_wdata(commit_wdata), .csr_cmd(csr_cmd),
    .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .trace_out(if1),
    .stall_req(stall1), .overflow(ovf1), .drop_count(drop1), .occupancy(occ1)
  );

  commit_trace_buffer #(.RETIRE_WIDTH(RW), .XLEN(XL), .ADDR_BITS(AB), .DEPTH(8), .DROP_MODE(0)) dut2 (
    .clock(clock), .reset_n(reset_n), .enable(enable), .commit_valid(commit_valid),
    .commit_pc(commit_pc), .commit_inst(commit_inst), .commit_rtype(commit_rtype),
    .commit_ldst(commit_ldst), .commit_wdata(commit_wdata), .csr_cmd(csr_cmd),
    .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .trace_out(if2),
    .stall_req(stall2), .overflow(ovf2), .drop_count(drop2), .occupancy(occ2)
  );

  always #5 clock = ~clock;

  // Expected timestamp for events driven at the current negedge.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) tb_cycle <= 64'd0;
    else tb_cycle <= tb_cycle + 64'd1;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    enable       = 1'b1;
    commit_valid = '0;
    commit_pc    = '0;
    commit_inst  = '0;
    commit_rtype = '0;
    commit_ldst  = '0;
    commit_wdata = '0;
    csr_cmd      = 3'd0;
    csr_addr     = 12'd0;
    csr_wdata    = '0;
    csr_rdata    = '0;
  endtask

  task automatic set_lane(input int l, input logic [AB-1:0] pc, input logic [31:0] inst,
                          input logic [2:0] rtype, input logic [4:0] ldst, input logic [XL-1:0] wdata);
    commit_valid[l]           = 1'b1;
    commit_pc[l*AB +: AB]     = pc;
    commit_inst[l*32 +: 32]   = inst;
    commit_rtype[l*3 +: 3]    = rtype;
    commit_ldst[l*5 +: 5]     = ldst;
    commit_wdata[l*XL +: XL]  = wdata;
  endtask

  // One capture cycle: lanes already set, CSR fields given here; inputs cleared after.
  task automatic applyStimulus(input logic [2:0] cmd, input logic [11:0] addr,
                               input logic [XL-1:0] wdata, input logic [XL-1:0] rdata);
    csr_cmd   = cmd;
    csr_addr  = addr;
    csr_wdata = wdata;
    csr_rdata = rdata;
    @(negedge clock);
    clear_inputs();
  endtask

  initial begin
    int idx;
    logic rdy;
    clear_inputs();
    if0.out_ready = 1'b0;
    if1.out_ready = 1'b0;
    if2.out_ready = 1'b0;
    #1 reset_n = 1'b0;
    #2;
    checkOutput("rst_valid", {63'd0, if0.out_valid}, 64'd0);
    checkOutput("rst_occ", {59'd0, occ0}, 64'd0);
    checkOutput("rst_drop", {32'd0, drop0}, 64'd0);
    checkOutput("rst_ovf", {63'd0, ovf0}, 64'd0);
    checkOutput("rst_stall", {63'd0, stall0}, 64'd0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    // Lane compaction with a CSR set event.
    cyc = tb_cycle;
    set_lane(0, 40'h1000, 32'h0000_0011, 3'd0, 5'd7, 64'hAAAA);
    set_lane(2, 40'h1008, 32'h0000_0033, 3'd1, 5'd3, 64'hBBBB);
    applyStimulus(3'd6, 12'h300, 64'h0F, 64'hF0);
    checkOutput("cmp_cycle0", cyc, 64'd0);
    checkOutput("cmp_occ", {59'd0, occ0}, 64'd3);
    checkOutput("cmp_valid", {63'd0, if0.out_valid}, 64'd1);
    checkOutput("cmp0_kind", {62'd0, if0.out_kind}, 64'd0);
    checkOutput("cmp0_addr", {52'd0, if0.out_addr}, 64'd7);
    checkOutput("cmp0_pc", {24'd0, if0.out_pc}, 64'h1000);
    checkOutput("cmp0_inst", {32'd0, if0.out_inst}, 64'h11);
    checkOutput("cmp0_data", if0.out_data, 64'hAAAA);
    checkOutput("cmp0_cycle", if0.out_cycle, cyc);
    if0.out_ready = 1'b1;
    applyStimulus(3'd0, 12'h0, 64'h0, 64'h0);
    checkOutput("cmp1_kind", {62'd0, if0.out_kind}, 64'd1);
    checkOutput("cmp1_addr", {52'd0, if0.out_addr}, 64'd3);
    checkOutput("cmp1_data", if0.out_data, 64'hBBBB);
    checkOutput("cmp1_cycle", if0.out_cycle, cyc);
    applyStimulus(3'd0, 12'h0, 64'h0, 64'h0);
    checkOutput("cmp2_kind", {62'd0, if0.out_kind}, 64'd3);
    checkOutput("cmp2_addr", {52'd0, if0.out_addr}, 64'h300);
    checkOutput("cmp2_data", if0.out_data, 64'hFF);
    checkOutput("cmp2_pc", {24'd0, if0.out_pc}, 64'd0);
    checkOutput("cmp2_inst", {32'd0, if0.out_inst}, 64'd0);
    checkOutput("cmp2_cycle", if0.out_cycle, cyc);
    applyStimulus(3'd0, 12'h0, 64'h0, 64'h0);
    checkOutput("cmp_empty", {63'd0, if0.out_valid}, 64'd0);

    // CSR clear resolution.
    cyc = tb_cycle;
    applyStimulus(3'd7, 12'h301, 64'h0F, 64'hFF);
    checkOutput("clr_kind", {62'd0, if0.out_kind}, 64'd3);
    checkOutput("clr_data", if0.out_data, 64'hF0);
    checkOutput("clr_addr", {52'd0, if0.out_addr}, 64'h301);
    checkOutput("clr_cycle", if0.out_cycle, cyc);
    applyStimulus(3'd0, 12'h0, 64'h0, 64'h0);
    checkOutput("clr_empty", {63'd0, if0.out_valid}, 64'd0);

    reset_n = 1'b0;
    if0.out_ready = 1'b0;
    applyStimulus(3'd0, 12'h0, 64'h0, 64'h0);
    reset_n = 1'b1;

    // Drop mode (dut1, DEPTH 4) and stall mode (dut2, DEPTH 8), 3 events per cycle.
    for (int l = 0; l < RW; l++) set_lane(l, 40'h2000 + 40'(4*l), 32'h13, 3'd0, 5'(1 + l), 64'(l));
    applyStimulus(3'd0, 12'h0, 64'h0, 64'h0);
    checkOutput("drop_a_occ", {61'd0, occ1}, 64'd3);
    checkOutput("drop_a_cnt", {32'd0, drop1}, 64'd0);
    checkOutput("stall_a_occ", {60'd0, occ2}, 64'd3);
    checkOutput("stall_a_req", {63'd0, stall2}, 64'd0);
    for (int l = 0; l < RW; l++) set_lane(l, 40'h2010 + 40'(4*l), 32'h13, 3'd0, 5'(4 + l), 64'(l));
    applyStimulus(3'd0, 12'h0, 64'h0, 64'h0);
    checkOutput("drop_b_occ", {61'd0, occ1}, 64'd3);
    checkOutput("drop_b_cnt", {32'd0, drop1}, 64'd3);
    checkOutput("drop_b_ovf", {63'd0, ovf1}, 64'd1);
    checkOutput("drop_b_stall", {63'd0, stall1}, 64'd0);
    checkOutput("stall_b_occ", {60'd0, occ2}, 64'd6);
    checkOutput("stall_b_req", {63'd0, stall2}, 64'd1);
    checkOutput("stall_b_drop", {32'd0, drop2}, 64'd0);
    checkOutput("stall_b_ovf", {63'd0, ovf2}, 64'd0);
    applyStimulus(3'd5, 12'h340, 64'h1, 64'h0);
    checkOutput("fit_occ", {61'd0, occ1}, 64'd4);
    checkOutput("fit_cnt", {32'd0, drop1}, 64'd3);
    checkOutput("fit_head", {52'd0, if1.out_addr}, 64'd1);
    applyStimulus(3'd5, 12'h340, 64'h2, 64'h0);
    checkOutput("full_cnt", {32'd0, drop1}, 64'd4);
    checkOutput("stall_d_occ", {60'd0, occ2}, 64'd8);
    checkOutput("stall_d_drop", {32'd0, drop2}, 64'd0);

    // Asynchronous reset while dut0 is draining.
    if0.out_ready = 1'b1;
    applyStimulus(3'd0, 12'h0, 64'h0, 64'h0);
    checkOutput("mid_occ", {59'd0, occ0}, 64'd7);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("arst_valid", {63'd0, if0.out_valid}, 64'd0);
    checkOutput("arst_occ", {59'd0, occ0}, 64'd0);
    checkOutput("arst_drop1", {32'd0, drop1}, 64'd0);
    checkOutput("arst_ovf1", {63'd0, ovf1}, 64'd0);
    checkOutput("arst_stall2", {63'd0, stall2}, 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    set_lane(0, 40'h3000, 32'h73, 3'd2, 5'd9, 64'h1234);
    applyStimulus(3'd0, 12'h0, 64'h0, 64'h0);
    checkOutput("arst_cycle", if0.out_cycle, 64'd0);
    checkOutput("ret_kind", {62'd0, if0.out_kind}, 64'd2);
    checkOutput("ret_data", if0.out_data, 64'd0);
    checkOutput("ret_addr", {52'd0, if0.out_addr}, 64'd9);
    applyStimulus(3'd0, 12'h0, 64'h0, 64'h0);
    checkOutput("ret_empty", {63'd0, if0.out_valid}, 64'd0);

    // Capture disabled.
    enable = 1'b0;
    set_lane(1, 40'h3100, 32'h13, 3'd0, 5'd1, 64'h1);
    applyStimulus(3'd5, 12'h300, 64'h1, 64'h0);
    checkOutput("dis_occ", {59'd0, occ0}, 64'd0);

    // Backpressure: six records drained with out_ready toggling 1,0,1,0...
    if0.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bp_exp[i] = '{kind: KIND_GPR, cycle: 64'd0, pc: 40'h4000 + 40'(4*i),
                    inst: 32'h13, addr: 12'(10 + i), data: 64'h5000 + 64'(i)};
    end
    for (int c = 0; c < 2; c++) begin
      for (int l = 0; l < RW; l++) begin
        set_lane(l, bp_exp[c*RW+l].pc, 32'h13, 3'd0, bp_exp[c*RW+l].addr[4:0], bp_exp[c*RW+l].data);
      end
      applyStimulus(3'd0, 12'h0, 64'h0, 64'h0);
    end
    checkOutput("bp_fill", {59'd0, occ0}, 64'd6);
    idx = 0;
    rdy = 1'b1;
    for (int c = 0; c < 16 && idx < 6; c++) begin
      if (if0.out_valid) begin
        checkOutput("bp_pc", {24'd0, if0.out_pc}, {24'd0, bp_exp[idx].pc});
        checkOutput("bp_addr", {52'd0, if0.out_addr}, {52'd0, bp_exp[idx].addr});
        checkOutput("bp_data", if0.out_data, bp_exp[idx].data);
      end else begin
        checkOutput("bp_valid", {63'd0, if0.out_valid}, 64'd1);
      end
      if0.out_ready = rdy;
      if (rdy && if0.out_valid) idx++;
      rdy = ~rdy;
      @(negedge clock);
    end
    checkOutput("bp_count", 64'(idx), 64'd6);
    checkOutput("bp_empty", {63'd0, if0.out_valid}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
